// File: rtl/counter_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl_if
//   Bundles the board-side controls and the counter-datapath signals of the
//   sequencing controller.
//
//   Signal semantics:
//     start, stop  : levels, sampled on every rising clk edge; stop wins when
//                    both are high.
//     mode         : run mode, only sampled on the edge that starts a run.
//     cnt_val      : counter value fed back from the datapath.
//     cnt_en       : single-cycle pulse, the datapath steps once per pulse.
//     dir          : level, 0 = count up, 1 = count down. The datapath uses it
//                    together with cnt_en.
//     cnt_clr      : single-cycle synchronous clear request.
//     busy         : level, high while a run is active or paused.
//     done         : single-cycle pulse when a single-shot run completes.
//     state        : controller state, 0=IDLE 1=RUN 2=PAUSE 3=DONE.
//   There is no back-pressure. Every pulse is consumed on the edge that
//   follows it.
//
//   Modports:
//     master : the controller (drives cnt_en/dir/cnt_clr/busy/done/state)
//     slave  : the board logic plus the counter datapath
// -----------------------------------------------------------------------------
interface counter_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [WIDTH-1:0] cnt_val;
    logic             cnt_en;
    logic             dir;
    logic             cnt_clr;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        input  start, stop, mode, cnt_val,
        output cnt_en, dir, cnt_clr, busy, done, state
    );

    modport slave (
        output start, stop, mode, cnt_val,
        input  cnt_en, dir, cnt_clr, busy, done, state
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
//   Sequencing controller for the up/down LED counter datapath. It owns the
//   tick prescaler and a run/pause/done state machine. It issues one-cycle
//   count enables together with the count direction. Four run modes are
//   supported: up, down, ping-pong and single-shot up.
//
//   Ports:
//     clk    : system clock
//     reset  : asynchronous, active-high reset (released synchronously)
//     bus    : counter_seq_ctrl_if.master
//              inputs  start, stop, mode, cnt_val
//              outputs cnt_en, dir, cnt_clr, busy, done, state
//   All outputs are registered.
//
//   Parameters:
//     WIDTH : counter width; must match the datapath
//     DIV   : clk cycles per count tick, 2..2^27-1
//     DIV_W : prescaler width; DIV-1 must fit
// -----------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 100000000,
    parameter int DIV_W = 27
) (
    input  logic                  clk,
    input  logic                  reset,
    counter_seq_ctrl_if.master    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;

    localparam logic [1:0] MODE_UP     = 2'd0;
    localparam logic [1:0] MODE_DOWN   = 2'd1;
    localparam logic [1:0] MODE_PING   = 2'd2;
    localparam logic [1:0] MODE_SINGLE = 2'd3;

    state_t           state_q,   state_d;
    logic [DIV_W-1:0] presc_q,   presc_d;
    logic [1:0]       mode_q,    mode_d;
    logic             dir_q,     dir_d;
    logic             cnt_en_q,  cnt_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             done_q,    done_d;
    logic             busy_q,    busy_d;

    // Single-shot completion: the counter reached its top value and no step
    // is pending. A clear that is still in flight means cnt_val is stale,
    // so the check is skipped in that cycle.
    logic single_end;
    assign single_end = (mode_q == MODE_SINGLE) && (bus.cnt_val == CNT_MAX) &&
                        !cnt_en_q && !cnt_clr_q;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start && !bus.stop) begin
                    state_d   = ST_RUN;
                    mode_d    = bus.mode;
                    dir_d     = (bus.mode == MODE_DOWN);
                    presc_d   = '0;
                    cnt_clr_d = (bus.mode == MODE_SINGLE);
                end
            end

            ST_RUN: begin
                // Direction follows the latched mode on every RUN cycle. In
                // ping-pong the turn is registered one cycle after the counter
                // hits an end. DIV >= 2 keeps that ahead of the next cnt_en.
                case (mode_q)
                    MODE_UP:   dir_d = 1'b0;
                    MODE_DOWN: dir_d = 1'b1;
                    MODE_PING: begin
                        if (!dir_q && bus.cnt_val == CNT_MAX) begin
                            dir_d = 1'b1;
                        end else if (dir_q && bus.cnt_val == '0) begin
                            dir_d = 1'b0;
                        end
                    end
                    default:   dir_d = 1'b0;
                endcase

                if (bus.stop) begin
                    // The prescaler holds, so a resume picks up mid-tick.
                    state_d = ST_PAUSE;
                end else if (single_end) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    presc_d = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d  = '0;
                    cnt_en_d = 1'b1;
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end

            ST_PAUSE: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            mode_q    <= 2'd0;
            dir_q     <= 1'b0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.cnt_en  = cnt_en_q;
    assign bus.dir     = dir_q;
    assign bus.cnt_clr = cnt_clr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.state   = state_q;

endmodule
